fighter_anim_sequencer: RTL and testbench

//  Sequences one fighter's sprite animation: picks the pose state and frame index that drive the

---
 rtl/fighter_anim_sequencer.sv | 138 +++++++++++++
 tb/tb_fighter_anim_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fighter_anim_sequencer.sv
// Fighter sprite animation sequencer: picks pose state and frame index, advancing on divided frame_clk edges.
// Optional ANIM_HURT_RETRIGGER_EN: a new hit while already hurt restarts the hurt animation at frame 0.
module fighter_anim_sequencer #(
  parameter int unsigned TICKS_PER_FRAME  = 4,
  parameter int unsigned STAND_FRAMES     = 9,
  parameter int unsigned MOVEL_FRAMES     = 10,
  parameter int unsigned MOVER_FRAMES     = 9,
  parameter int unsigned ATTACK_FRAMES    = 6,
  parameter int unsigned DEFENSE_FRAMES   = 1,
  parameter int unsigned HURT_FRAMES      = 5,
  parameter int unsigned ATTACK_HIT_FRAME = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       move_l,
  input  logic       move_r,
  input  logic       defend,
  input  logic       attack_req,
  input  logic       hurt_in,
  output logic [7:0] anim_state,
  output logic [7:0] frame_num,
  output logic       busy,
  output logic       hit_pulse,
  output logic       anim_tick
);

  localparam int DIV_W = $clog2(TICKS_PER_FRAME + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_FRAME - 1);

`ifdef ANIM_HURT_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_STAND   = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_MOVEL   = 3'd2,
    ST_MOVER   = 3'd3,
    ST_DEFENSE = 3'd4,
    ST_HURT    = 3'd5
  } state_t;

  state_t           state, state_n, choice;
  logic [7:0]       frame, frame_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic             sync1, sync2, prev;
  logic             atk_pend, atk_n, hurt_pend, hurt_n;
  logic             busy_n, hit_n;
  logic             tick, adv, atk_eff, hurt_eff;

  function automatic logic [7:0] last_of(input state_t s);
    case (s)
      ST_ATTACK:  return 8'(ATTACK_FRAMES - 1);
      ST_MOVEL:   return 8'(MOVEL_FRAMES - 1);
      ST_MOVER:   return 8'(MOVER_FRAMES - 1);
      ST_DEFENSE: return 8'(DEFENSE_FRAMES - 1);
      ST_HURT:    return 8'(HURT_FRAMES - 1);
      default:    return 8'(STAND_FRAMES - 1);
    endcase
  endfunction

  assign tick     = sync2 & ~prev;
  assign adv      = tick && (div_cnt == DIV_LAST);
  // Requests arriving on the adv cycle itself count for that adv.
  assign atk_eff  = atk_pend | attack_req;
  assign hurt_eff = hurt_pend | hurt_in;

  always_comb begin
    state_n = state;
    frame_n = frame;
    div_n   = div_cnt;
    atk_n   = atk_eff;
    hurt_n  = hurt_eff;
    choice  = ST_STAND;
    if (tick) div_n = (div_cnt == DIV_LAST) ? '0 : DIV_W'(div_cnt + 1'b1);
    if (adv) begin
      hurt_n = 1'b0;
      if (hurt_eff && (state != ST_HURT || RETRIGGER)) begin
        state_n = ST_HURT;
        frame_n = 8'd0;
        atk_n   = 1'b0;
      end else if ((state == ST_ATTACK || state == ST_HURT) && frame < last_of(state)) begin
        frame_n = frame + 8'd1;
      end else begin
        if (atk_eff) begin
          choice = ST_ATTACK;
          atk_n  = 1'b0;
        end else if (defend)            choice = ST_DEFENSE;
        else if (move_l && !move_r)     choice = ST_MOVEL;
        else if (move_r && !move_l)     choice = ST_MOVER;
        else                            choice = ST_STAND;
        // Looping poses keep counting; a one-shot or a pose change starts from frame 0.
        if (choice == state && choice != ST_ATTACK)
          frame_n = (frame == last_of(state)) ? 8'd0 : frame + 8'd1;
        else
          frame_n = 8'd0;
        state_n = choice;
      end
    end
    busy_n = (state_n == ST_ATTACK) || (state_n == ST_HURT);
    hit_n  = adv && (state_n == ST_ATTACK) && (frame_n == 8'(ATTACK_HIT_FRAME));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_STAND;
      frame     <= 8'd0;
      div_cnt   <= '0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b0;
      atk_pend  <= 1'b0;
      hurt_pend <= 1'b0;
      busy      <= 1'b0;
      hit_pulse <= 1'b0;
      anim_tick <= 1'b0;
    end else begin
      state     <= state_n;
      frame     <= frame_n;
      div_cnt   <= div_n;
      sync1     <= frame_clk;
      sync2     <= sync1;
      prev      <= sync2;
      atk_pend  <= atk_n;
      hurt_pend <= hurt_n;
      busy      <= busy_n;
      hit_pulse <= hit_n;
      anim_tick <= adv;
    end
  end

  assign anim_state = {5'd0, state};
  assign frame_num  = frame;

endmodule

// File: tb/tb_fighter_anim_sequencer.sv
// Directed, table-driven bench for fighter_anim_sequencer with TICKS_PER_FRAME=2.
module tb_fighter_anim_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       move_l = 1'b0, move_r = 1'b0, defend = 1'b0;
  logic       attack_req = 1'b0, hurt_in = 1'b0;
  logic [7:0] anim_state, frame_num;
  logic       busy, hit_pulse, anim_tick;

  int n_vec = 0;
  int n_fail = 0;
  int hit_cnt = 0;
  int tick_cnt = 0;
  int bad_hit = 0;

  fighter_anim_sequencer #(.TICKS_PER_FRAME(2)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .move_l(move_l), .move_r(move_r), .defend(defend),
    .attack_req(attack_req), .hurt_in(hurt_in),
    .anim_state(anim_state), .frame_num(frame_num),
    .busy(busy), .hit_pulse(hit_pulse), .anim_tick(anim_tick)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (hit_pulse) hit_cnt++;
    if (anim_tick) tick_cnt++;
    if (hit_pulse && !(anim_state == 8'd1 && frame_num == 8'd3)) bad_hit++;
  end

  typedef struct {
    logic       atk;
    logic       hurt;
    logic       ml;
    logic       mr;
    logic       df;
    int         edges;
    logic [7:0] st;
    logic [7:0] fr;
    logic       bz;
    int         hits;
  } vec_t;

  vec_t vecs[29];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic frame_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk) frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
    end
  endtask

  task automatic pulse(input logic atk, input logic hurt);
    if (atk || hurt) begin
      @(negedge Clk);
      attack_req = atk;
      hurt_in    = hurt;
      @(negedge Clk);
      attack_req = 1'b0;
      hurt_in    = 1'b0;
    end
  endtask

  initial begin
    int h0, t0;
    vecs[0]  = '{0, 0, 1, 0, 0,  2, 8'd2, 8'd0, 0, 0};
    vecs[1]  = '{0, 0, 1, 0, 0, 18, 8'd2, 8'd9, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 0,  2, 8'd2, 8'd0, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 0,  2, 8'd0, 8'd0, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 1,  2, 8'd4, 8'd0, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 1,  4, 8'd4, 8'd0, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 0,  2, 8'd3, 8'd0, 0, 0};
    vecs[7]  = '{0, 0, 0, 1, 0,  2, 8'd3, 8'd1, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0,  2, 8'd0, 8'd0, 0, 0};
    vecs[9]  = '{1, 0, 0, 0, 0,  2, 8'd1, 8'd0, 1, 0};
    vecs[10] = '{0, 0, 0, 0, 0,  6, 8'd1, 8'd3, 1, 1};
    vecs[11] = '{0, 0, 0, 0, 0,  4, 8'd1, 8'd5, 1, 0};
    vecs[12] = '{0, 0, 0, 0, 0,  2, 8'd0, 8'd0, 0, 0};
    vecs[13] = '{1, 0, 0, 0, 0,  2, 8'd1, 8'd0, 1, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 10, 8'd1, 8'd5, 1, 1};
    vecs[15] = '{0, 0, 0, 0, 0,  2, 8'd1, 8'd0, 1, 0};
    vecs[16] = '{0, 0, 0, 0, 0, 10, 8'd1, 8'd5, 1, 1};
    vecs[17] = '{0, 0, 0, 0, 0,  2, 8'd0, 8'd0, 0, 0};
    vecs[18] = '{1, 0, 0, 0, 0,  4, 8'd1, 8'd1, 1, 0};
    vecs[19] = '{0, 1, 0, 0, 0,  2, 8'd5, 8'd0, 1, 0};
    vecs[20] = '{0, 0, 0, 0, 0,  8, 8'd5, 8'd4, 1, 0};
    vecs[21] = '{0, 0, 0, 0, 0,  2, 8'd0, 8'd0, 0, 0};
    vecs[22] = '{0, 1, 0, 0, 0,  2, 8'd5, 8'd0, 1, 0};
    vecs[23] = '{0, 0, 0, 0, 0,  4, 8'd5, 8'd2, 1, 0};
`ifdef ANIM_HURT_RETRIGGER_EN
    vecs[24] = '{0, 1, 0, 0, 0,  2, 8'd5, 8'd0, 1, 0};
    vecs[25] = '{0, 0, 0, 0, 0,  2, 8'd5, 8'd1, 1, 0};
    vecs[26] = '{0, 0, 0, 0, 0,  2, 8'd5, 8'd2, 1, 0};
    vecs[27] = '{0, 0, 0, 0, 0,  4, 8'd5, 8'd4, 1, 0};
    vecs[28] = '{0, 0, 0, 0, 0,  2, 8'd0, 8'd0, 0, 0};
`else
    vecs[24] = '{0, 1, 0, 0, 0,  2, 8'd5, 8'd3, 1, 0};
    vecs[25] = '{0, 0, 0, 0, 0,  2, 8'd5, 8'd4, 1, 0};
    vecs[26] = '{0, 0, 0, 0, 0,  2, 8'd0, 8'd0, 0, 0};
    vecs[27] = '{0, 0, 0, 0, 0,  4, 8'd0, 8'd2, 0, 0};
    vecs[28] = '{0, 0, 0, 0, 0,  2, 8'd0, 8'd3, 0, 0};
`endif

    // Reset state
    repeat (3) @(negedge Clk);
    check("reset_state", anim_state, 0);
    check("reset_frame", frame_num, 0);
    check("reset_busy", busy, 0);
    check("reset_hit", hit_pulse, 0);
    check("reset_tick", anim_tick, 0);
    Reset = 1'b0;

    // Idle stand loop: frame changes every second frame_clk edge and wraps 8 -> 0
    for (int i = 1; i <= 20; i++) begin
      frame_edges(1);
      check($sformatf("stand_state_%0d", i), anim_state, 0);
      check($sformatf("stand_frame_%0d", i), frame_num, (i / 2) % 9);
    end

    for (int v = 0; v < 29; v++) begin
      move_l = vecs[v].ml;
      move_r = vecs[v].mr;
      defend = vecs[v].df;
      h0 = hit_cnt;
      t0 = tick_cnt;
      pulse(vecs[v].atk, vecs[v].hurt);
      frame_edges(vecs[v].edges);
      check($sformatf("v%0d_state", v), anim_state, vecs[v].st);
      check($sformatf("v%0d_frame", v), frame_num, vecs[v].fr);
      check($sformatf("v%0d_busy", v), busy, vecs[v].bz);
      check($sformatf("v%0d_hits", v), hit_cnt - h0, vecs[v].hits);
      check($sformatf("v%0d_ticks", v), tick_cnt - t0, vecs[v].edges / 2);
    end
    move_l = 1'b0;
    move_r = 1'b0;
    defend = 1'b0;

    // Reset mid-attack with a second attack pending: everything clears, nothing resumes
    pulse(1'b1, 1'b0);
    frame_edges(10);
    check("pre_rst_state", anim_state, 1);
    check("pre_rst_frame", frame_num, 4);
    pulse(1'b1, 1'b0);
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk);
    check("rst_state", anim_state, 0);
    check("rst_frame", frame_num, 0);
    check("rst_busy", busy, 0);
    check("rst_hit", hit_pulse, 0);
    check("rst_tick", anim_tick, 0);
    Reset = 1'b0;
    frame_edges(4);
    check("post_rst_state", anim_state, 0);
    check("post_rst_frame", frame_num, 2);
    check("post_rst_busy", busy, 0);

    check("hit_alignment", bad_hit, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
